div_seq: RTL and testbench

Multi-cycle 32-bit divider sequencer for the EX stage. It accepts a div/divu request from EX, runs a 32-iteration restoring-division datapath under an FSM, and returns {remainder, quotient} for HI/LO writeback. It also drives the stall request that holds the pipeline while the divide is in flight, and supports annulment when the issuing instruction is flushed.

---
 rtl/div_seq.sv | 160 ++++++++++++++++
 tb/tb_div_seq.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/div_seq.sv
// Multi-cycle restoring divider for the EX stage: signed/unsigned 32-bit divide
// producing {remainder, quotient}, with pipeline stall request and flush annulment.
module div_seq #(
  parameter int unsigned DATA_W = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  signed_div_i,
  input  logic [DATA_W-1:0]     opdata1_i,
  input  logic [DATA_W-1:0]     opdata2_i,
  input  logic                  start_i,
  input  logic                  annul_i,
  output logic [2*DATA_W-1:0]   result_o,
  output logic                  ready_o,
  output logic                  stallreq_o
);

  localparam int unsigned WORK_W = 2 * DATA_W;
  localparam int unsigned CNT_W  = $clog2(DATA_W);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_BYZERO,
    S_ON,
    S_END
  } state_t;

  state_t                r_state, w_state_nxt;
  logic [CNT_W-1:0]      r_cnt, w_cnt_nxt;
  logic [WORK_W-1:0]     r_work, w_work_nxt;
  logic [DATA_W-1:0]     r_divisor, w_divisor_nxt;
  logic                  r_quo_neg, w_quo_neg_nxt;
  logic                  r_rem_neg, w_rem_neg_nxt;
  logic [2*DATA_W-1:0]   r_result, w_result_nxt;
  logic                  r_ready, w_ready_nxt;

  logic [DATA_W-1:0]     w_op1_abs;
  logic [DATA_W-1:0]     w_op2_abs;
  logic [DATA_W:0]       w_diff;
  logic [WORK_W:0]       w_step;
  logic [DATA_W-1:0]     w_quo_raw;
  logic [DATA_W-1:0]     w_rem_raw;
  logic [DATA_W-1:0]     w_quo;
  logic [DATA_W-1:0]     w_rem;

  // Operand magnitudes; unsigned operands pass through untouched.
  assign w_op1_abs = (signed_div_i && opdata1_i[DATA_W-1]) ? (~opdata1_i + DATA_W'(1)) : opdata1_i;
  assign w_op2_abs = (signed_div_i && opdata2_i[DATA_W-1]) ? (~opdata2_i + DATA_W'(1)) : opdata2_i;

  // One restoring step. Work layout: partial remainder above bit DATA_W,
  // remaining dividend bits below it, quotient bits shifting in at bit 0.
  // The always-zero top bit of the full work word is not stored.
  assign w_diff = {1'b0, r_work[WORK_W-1:DATA_W]} - {1'b0, r_divisor};
  assign w_step = w_diff[DATA_W] ? {r_work, 1'b0}
                                 : {w_diff[DATA_W-1:0], r_work[DATA_W-1:0], 1'b1};

  assign w_quo_raw = w_step[DATA_W-1:0];
  assign w_rem_raw = w_step[WORK_W:DATA_W+1];
  assign w_quo     = r_quo_neg ? (~w_quo_raw + DATA_W'(1)) : w_quo_raw;
  assign w_rem     = r_rem_neg ? (~w_rem_raw + DATA_W'(1)) : w_rem_raw;

  // State and datapath registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_work    <= '0;
      r_divisor <= '0;
      r_quo_neg <= 1'b0;
      r_rem_neg <= 1'b0;
      r_result  <= '0;
      r_ready   <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_cnt     <= w_cnt_nxt;
      r_work    <= w_work_nxt;
      r_divisor <= w_divisor_nxt;
      r_quo_neg <= w_quo_neg_nxt;
      r_rem_neg <= w_rem_neg_nxt;
      r_result  <= w_result_nxt;
      r_ready   <= w_ready_nxt;
    end
  end

  // Next-state and next-datapath logic.
  always_comb begin
    w_state_nxt   = r_state;
    w_cnt_nxt     = r_cnt;
    w_work_nxt    = r_work;
    w_divisor_nxt = r_divisor;
    w_quo_neg_nxt = r_quo_neg;
    w_rem_neg_nxt = r_rem_neg;
    w_result_nxt  = r_result;
    w_ready_nxt   = r_ready;

    case (r_state)
      S_IDLE: begin
        if (start_i && !annul_i) begin
          if (opdata2_i == '0) begin
            w_state_nxt = S_BYZERO;
          end else begin
            w_state_nxt   = S_ON;
            w_work_nxt    = {{(DATA_W-1){1'b0}}, w_op1_abs, 1'b0};
            w_divisor_nxt = w_op2_abs;
            w_quo_neg_nxt = signed_div_i && (opdata1_i[DATA_W-1] ^ opdata2_i[DATA_W-1]);
            w_rem_neg_nxt = signed_div_i && opdata1_i[DATA_W-1];
            w_cnt_nxt     = '0;
          end
        end
      end

      S_BYZERO: begin
        if (annul_i) begin
          w_state_nxt = S_IDLE;
        end else begin
          w_state_nxt  = S_END;
          w_result_nxt = '0;
          w_ready_nxt  = 1'b1;
        end
      end

      S_ON: begin
        if (annul_i) begin
          w_state_nxt = S_IDLE;
          w_cnt_nxt   = '0;
        end else begin
          w_work_nxt = w_step[WORK_W-1:0];
          w_cnt_nxt  = r_cnt + CNT_W'(1);
          if (r_cnt == CNT_LAST) begin
            w_state_nxt  = S_END;
            w_result_nxt = {w_rem, w_quo};
            w_ready_nxt  = 1'b1;
          end
        end
      end

      S_END: begin
        if (!start_i || annul_i) begin
          w_state_nxt  = S_IDLE;
          w_result_nxt = '0;
          w_ready_nxt  = 1'b0;
        end
      end

      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // Stall drops in END so EX advances in the cycle the result is presented.
  assign stallreq_o = ((r_state == S_IDLE) && start_i && !annul_i)
                   || (r_state == S_BYZERO)
                   || (r_state == S_ON);

  assign result_o = r_result;
  assign ready_o  = r_ready;

endmodule

// File: tb/tb_div_seq.sv
// Self-checking bench for div_seq: directed cases plus randomized divides
// compared against an arithmetic reference model.
module tb_div_seq;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        signed_div_i = 1'b0;
  logic [31:0] opdata1_i = '0;
  logic [31:0] opdata2_i = '0;
  logic        start_i = 1'b0;
  logic        annul_i = 1'b0;
  logic [63:0] result_o;
  logic        ready_o;
  logic        stallreq_o;

  int checks = 0;
  int errors = 0;

  bit          rs;
  logic [31:0] ra, rb;
  int          ready_seen;

  div_seq #(.DATA_W(32)) dut (
    .clk          (clk),
    .rst          (rst),
    .signed_div_i (signed_div_i),
    .opdata1_i    (opdata1_i),
    .opdata2_i    (opdata2_i),
    .start_i      (start_i),
    .annul_i      (annul_i),
    .result_o     (result_o),
    .ready_o      (ready_o),
    .stallreq_o   (stallreq_o)
  );

  always #5 clk = ~clk;

  // Reference: plain integer division, truncating toward zero; /0 gives 0/0.
  function automatic logic [63:0] ref_div(input bit s, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, q, r;
    if (b == 32'd0) return 64'd0;
    if (!s) return {a % b, a / b};
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    q  = sa / sb;
    r  = sa % sb;
    return {r[31:0], q[31:0]};
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Issue one divide, hold start through END for 'hold' extra cycles, then drop it.
  task automatic do_op(input bit s, input logic [31:0] a, input logic [31:0] b, input int hold);
    logic [63:0] exp;
    int k;
    bit seen;
    int stall_gaps;
    exp = ref_div(s, a, b);
    @(negedge clk);
    signed_div_i = s;
    opdata1_i    = a;
    opdata2_i    = b;
    start_i      = 1'b1;
    #1 chk("stall_issue", 64'(stallreq_o), 64'd1);
    seen = 0;
    stall_gaps = 0;
    for (k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (k == 1) begin
        opdata1_i    = $urandom;
        opdata2_i    = $urandom;
        signed_div_i = ~s;
      end
      if (ready_o) begin
        seen = 1;
        break;
      end
      if (!stallreq_o) stall_gaps++;
    end
    chk("ready_timeout", 64'(seen), 64'd1);
    if (b == 32'd0) chk("lat_zero_le_E2", 64'(k <= 3), 64'd1);
    else            chk("lat_E32", 64'(k), 64'd33);
    chk("stall_gaps", 64'(stall_gaps), 64'd0);
    chk("result", result_o, exp);
    chk("stall_end", 64'(stallreq_o), 64'd0);
    repeat (hold) begin
      @(negedge clk);
      chk("hold_ready", 64'(ready_o), 64'd1);
      chk("hold_result", result_o, exp);
    end
    start_i = 1'b0;
    @(negedge clk);
    chk("drop_ready", 64'(ready_o), 64'd0);
    chk("drop_result", result_o, 64'd0);
  endtask

  initial begin
    #1 rst = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_ready", 64'(ready_o), 64'd0);
    chk("rst_result", result_o, 64'd0);
    chk("rst_stall", 64'(stallreq_o), 64'd0);
    rst = 1'b0;
    @(negedge clk);

    // Directed cases with hand-derived expectations.
    chk("model_100_7", ref_div(1'b0, 32'd100, 32'd7), 64'h00000002_0000000E);
    do_op(1'b0, 32'd100, 32'd7, 0);
    chk("model_m7_2", ref_div(1'b1, 32'hFFFFFFF9, 32'h2), 64'hFFFFFFFF_FFFFFFFD);
    do_op(1'b1, 32'hFFFFFFF9, 32'h2, 1);
    chk("model_u_m7_2", ref_div(1'b0, 32'hFFFFFFF9, 32'h2), 64'h00000001_7FFFFFFC);
    do_op(1'b0, 32'hFFFFFFF9, 32'h2, 0);
    do_op(1'b1, 32'h1234, 32'h0, 2);
    chk("model_min_m1", ref_div(1'b1, 32'h80000000, 32'hFFFFFFFF), 64'h00000000_80000000);
    do_op(1'b1, 32'h80000000, 32'hFFFFFFFF, 0);
    do_op(1'b1, 32'h80000000, 32'h1, 0);

    // Annul partway through ON: no result, back to IDLE.
    @(negedge clk);
    signed_div_i = 1'b0;
    opdata1_i    = 32'd5000;
    opdata2_i    = 32'd3;
    start_i      = 1'b1;
    ready_seen   = 0;
    repeat (11) begin
      @(negedge clk);
      if (ready_o) ready_seen++;
    end
    annul_i = 1'b1;
    @(negedge clk);
    chk("annul_ready", 64'(ready_o), 64'd0);
    chk("annul_stall_idle", 64'(stallreq_o), 64'd0);
    start_i = 1'b0;
    annul_i = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (ready_o) ready_seen++;
    end
    chk("annul_no_ready", 64'(ready_seen), 64'd0);
    chk("annul_result", result_o, 64'd0);
    chk("model_ffff_10", ref_div(1'b0, 32'hFFFFFFFF, 32'h10), 64'h0000000F_0FFFFFFF);
    do_op(1'b0, 32'hFFFFFFFF, 32'h10, 0);

    // Asynchronous reset in the middle of ON.
    @(negedge clk);
    signed_div_i = 1'b1;
    opdata1_i    = 32'hFFFFFC18;
    opdata2_i    = 32'd3;
    start_i      = 1'b1;
    repeat (16) @(negedge clk);
    chk("mid_on_stall", 64'(stallreq_o), 64'd1);
    start_i = 1'b0;
    #2 rst = 1'b1;
    #1;
    chk("async_rst_stall", 64'(stallreq_o), 64'd0);
    chk("async_rst_ready", 64'(ready_o), 64'd0);
    chk("async_rst_result", result_o, 64'd0);
    #1 rst = 1'b0;
    ready_seen = 0;
    repeat (40) begin
      @(negedge clk);
      if (ready_o || stallreq_o) ready_seen++;
    end
    chk("post_rst_quiet", 64'(ready_seen), 64'd0);

    // Randomized divides, biased toward small, zero and all-ones divisors.
    for (int i = 0; i < 16; i++) begin
      rs = 1'($urandom_range(0, 1));
      ra = $urandom;
      case ($urandom_range(0, 5))
        0:       rb = 32'd0;
        1:       rb = 32'($urandom_range(1, 15));
        2:       rb = 32'hFFFFFFFF;
        default: rb = $urandom;
      endcase
      if (i == 3) ra = 32'h80000000;
      do_op(rs, ra, rb, int'($urandom_range(0, 2)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
